// File: rtl/param_ser_fifo_pkg.sv
// Shared definitions for the parameterised serialising FIFO:
// the serializer state encoding and the default geometry constants.
package param_ser_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_OUT_W  = 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/param_ser_fifo_mem.sv
// Word storage for param_ser_fifo: circular array with read/write
// pointers and an occupancy count. The caller guarantees that writes
// only happen when not full and reads only when not empty.
module param_ser_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       rd_data,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] store [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Array contents need no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            store[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign rd_data = store[rd_ptr];

endmodule

// File: rtl/param_ser_fifo.sv
// Parameterised FIFO whose words are emitted as OUT_W-bit serial slices.
// Optional macro PARAM_SER_FIFO_LEVEL_EN adds the fifo_level output
// (count of words still in storage, excluding the one being shifted).
module param_ser_fifo
    import param_ser_fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int LSB_FIRST = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [DATA_W-1:0]      fifo_input,
    input  logic                   fifo_input_valid,
    output logic                   fifo_input_ready,
    output logic [OUT_W-1:0]       fifo_output,
    output logic                   fifo_output_valid,
    input  logic                   fifo_output_ready,
    output logic                   overflow
`ifdef PARAM_SER_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] fifo_level
`endif
);

    localparam int NSLICE = DATA_W / OUT_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int LVL_W  = $clog2(DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    ser_state_t        state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] shifted;
    logic [OUT_W-1:0]  slice;
    logic [IDX_W-1:0]  slice_idx;
    logic [LVL_W-1:0]  level;
    logic              wr_en;
    logic              pop;
    logic              last_accept;

    // Full is judged on registered level, so a pop never frees a slot
    // for a write on the same edge.
    assign fifo_input_ready = (level != FULL_LVL);
    assign wr_en            = fifo_input_valid && fifo_input_ready;
    assign last_accept      = (state == SHIFT) && fifo_output_ready && (slice_idx == LAST_IDX);
    assign pop              = (level != '0) && ((state == IDLE) || last_accept);

    param_ser_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_data (fifo_input),
        .rd_en   (pop),
        .rd_data (head),
        .level   (level)
    );

    // Serializer: load a word when idle or right after its last slice goes out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            shreg     <= '0;
            slice_idx <= '0;
        end else if (pop) begin
            state     <= SHIFT;
            shreg     <= head;
            slice_idx <= '0;
        end else if (last_accept) begin
            state     <= IDLE;
        end else if ((state == SHIFT) && fifo_output_ready) begin
            slice_idx <= slice_idx + 1'b1;
        end
    end

    // Bring the selected slice to the end of the word the output is taken from.
    always_comb begin
        if (LSB_FIRST != 0) begin
            shifted = shreg >> (int'(slice_idx) * OUT_W);
        end else begin
            shifted = shreg << (int'(slice_idx) * OUT_W);
        end
    end

    assign slice             = (LSB_FIRST != 0) ? shifted[OUT_W-1:0] : shifted[DATA_W-1 -: OUT_W];
    assign fifo_output_valid = (state == SHIFT);
    assign fifo_output       = (state == SHIFT) ? slice : '0;

    // Sticky flag for any write attempted while storage was full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (fifo_input_valid && !fifo_input_ready) begin
            overflow <= 1'b1;
        end
    end

`ifdef PARAM_SER_FIFO_LEVEL_EN
    assign fifo_level = level;
`endif

endmodule

// File: tb/tb_param_ser_fifo.sv
// Self-checking bench for param_ser_fifo. Four instances cover the default
// geometry, MSB-first order, 4-bit slices and a 4-deep store.
// Expected slices are queued at stimulus time; monitors pop and compare.
module tb_param_ser_fifo;

    logic clk = 1'b0;
    logic reset_n;

    // Free-running clock shared by all instances.
    always #5 clk = ~clk;

    int vectors_applied = 0;
    int miscompares     = 0;

    // Instance 0: defaults
    logic [7:0] in0;
    logic       in_valid0, in_ready0, out0, out_valid0, out_ready0, ovf0;
    // Instance 1: MSB first
    logic [7:0] in1;
    logic       in_valid1, in_ready1, out1, out_valid1, out_ready1, ovf1;
    // Instance 2: 4-bit slices
    logic [7:0] in2;
    logic       in_valid2, in_ready2, out_valid2, out_ready2, ovf2;
    logic [3:0] out2;
    // Instance 3: DEPTH = 4
    logic [7:0] in3;
    logic       in_valid3, in_ready3, out3, out_valid3, out_ready3, ovf3;
`ifdef PARAM_SER_FIFO_LEVEL_EN
    logic [4:0] level0, level1, level2;
    logic [2:0] level3;
`endif

    bit         q0[$];
    bit         q1[$];
    logic [3:0] q2[$];
    bit         q3[$];

    int  accepted0 = 0;
    int  run0      = 0;
    int  last_run0 = 0;
    bit  hold0     = 1'b0;
    bit  held0     = 1'b0;
    bit  toggling  = 1'b0;

    param_ser_fifo dut0 (
        .clk(clk), .reset_n(reset_n),
        .fifo_input(in0), .fifo_input_valid(in_valid0), .fifo_input_ready(in_ready0),
        .fifo_output(out0), .fifo_output_valid(out_valid0), .fifo_output_ready(out_ready0),
        .overflow(ovf0)
`ifdef PARAM_SER_FIFO_LEVEL_EN
        , .fifo_level(level0)
`endif
    );

    param_ser_fifo #(.LSB_FIRST(0)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .fifo_input(in1), .fifo_input_valid(in_valid1), .fifo_input_ready(in_ready1),
        .fifo_output(out1), .fifo_output_valid(out_valid1), .fifo_output_ready(out_ready1),
        .overflow(ovf1)
`ifdef PARAM_SER_FIFO_LEVEL_EN
        , .fifo_level(level1)
`endif
    );

    param_ser_fifo #(.OUT_W(4)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .fifo_input(in2), .fifo_input_valid(in_valid2), .fifo_input_ready(in_ready2),
        .fifo_output(out2), .fifo_output_valid(out_valid2), .fifo_output_ready(out_ready2),
        .overflow(ovf2)
`ifdef PARAM_SER_FIFO_LEVEL_EN
        , .fifo_level(level2)
`endif
    );

    param_ser_fifo #(.DEPTH(4)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .fifo_input(in3), .fifo_input_valid(in_valid3), .fifo_input_ready(in_ready3),
        .fifo_output(out3), .fifo_output_valid(out_valid3), .fifo_output_ready(out_ready3),
        .overflow(ovf3)
`ifdef PARAM_SER_FIFO_LEVEL_EN
        , .fifo_level(level3)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors_applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic reportUnexpected(input string name);
        vectors_applied++;
        miscompares++;
        $display("[TB] FAIL %s: output valid with nothing expected", name);
    endtask

    // One-cycle write pulse; back-to-back calls give one write per cycle.
    task automatic applyStimulus(input int id, input logic [7:0] d);
        case (id)
            0: begin in0 = d; in_valid0 = 1'b1; end
            1: begin in1 = d; in_valid1 = 1'b1; end
            2: begin in2 = d; in_valid2 = 1'b1; end
            3: begin in3 = d; in_valid3 = 1'b1; end
            default: ;
        endcase
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        in_valid3 = 1'b0;
    endtask

    // LSB-first bit expectations for the 1-bit LSB-first instances.
    task automatic pushBits(input int id, input logic [7:0] d);
        for (int b = 0; b < 8; b++) begin
            if (id == 0) q0.push_back(d[b]);
            else         q3.push_back(d[b]);
        end
    endtask

    function automatic int queueSize(input int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic waitDrain(input int id, input int budget);
        for (int c = 0; c < budget && queueSize(id) != 0; c++) begin
            @(posedge clk);
            #1;
        end
        checkOutput($sformatf("drain%0d", id), queueSize(id), 0);
    endtask

    // Instance 0 monitor: in-order compare, hold stability, run length.
    always @(negedge clk) begin
        if (!reset_n) begin
            run0  = 0;
            hold0 = 1'b0;
        end else begin
            if (hold0) checkOutput("hold0", out0, held0);
            hold0 = out_valid0 && !out_ready0;
            held0 = out0;
            if (out_valid0) begin
                run0++;
            end else if (run0 != 0) begin
                last_run0 = run0;
                run0      = 0;
            end
            if (out_valid0 && out_ready0) begin
                accepted0++;
                if (q0.size() == 0) reportUnexpected("out0");
                else                checkOutput("bit0", out0, q0.pop_front());
            end
        end
    end

    // Instance 1 monitor.
    always @(negedge clk) begin
        if (reset_n && out_valid1 && out_ready1) begin
            if (q1.size() == 0) reportUnexpected("out1");
            else                checkOutput("bit1", out1, q1.pop_front());
        end
    end

    // Instance 2 monitor.
    always @(negedge clk) begin
        if (reset_n && out_valid2 && out_ready2) begin
            if (q2.size() == 0) reportUnexpected("out2");
            else                checkOutput("slice2", out2, q2.pop_front());
        end
    end

    // Instance 3 monitor.
    always @(negedge clk) begin
        if (reset_n && out_valid3 && out_ready3) begin
            if (q3.size() == 0) reportUnexpected("out3");
            else                checkOutput("bit3", out3, q3.pop_front());
        end
    end

    // Hard stop in case something never drains.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] stream [8];
        stream = '{8'h07, 8'h03, 8'h01, 8'h05, 8'h21, 8'h43, 8'h65, 8'h87};

        reset_n   = 1'b0;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        in_valid0 = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0; in_valid3 = 1'b0;
        out_ready0 = 1'b1; out_ready1 = 1'b1; out_ready2 = 1'b1; out_ready3 = 1'b0;
        #1;
        $display("[TB] reset state");
        checkOutput("rst_valid0", out_valid0, 1'b0);
        checkOutput("rst_out0",   out0,       1'b0);
        checkOutput("rst_ready0", in_ready0,  1'b1);
        checkOutput("rst_ovf0",   ovf0,       1'b0);
        checkOutput("rst_ready3", in_ready3,  1'b1);
`ifdef PARAM_SER_FIFO_LEVEL_EN
        checkOutput("rst_level0", level0, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        $display("[TB] eight-byte stream, sink always ready");
        for (int i = 0; i < 8; i++) pushBits(0, stream[i]);
        for (int i = 0; i < 8; i++) applyStimulus(0, stream[i]);
        waitDrain(0, 200);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("run_length", last_run0, 64);

        $display("[TB] same stream, sink ready toggling");
        toggling = 1'b1;
        fork
            begin
                while (toggling) begin
                    @(posedge clk);
                    #1;
                    out_ready0 = ~out_ready0;
                end
            end
            begin
                for (int i = 0; i < 8; i++) pushBits(0, stream[i]);
                for (int i = 0; i < 8; i++) applyStimulus(0, stream[i]);
                waitDrain(0, 400);
                toggling = 1'b0;
            end
        join
        out_ready0 = 1'b1;

        $display("[TB] MSB-first and 4-bit slice ordering");
        q1.push_back(1'b1); q1.push_back(1'b0); q1.push_back(1'b1); q1.push_back(1'b0);
        q1.push_back(1'b0); q1.push_back(1'b1); q1.push_back(1'b0); q1.push_back(1'b1);
        applyStimulus(1, 8'hA5);
        q2.push_back(4'h3);
        q2.push_back(4'h4);
        applyStimulus(2, 8'h43);
        waitDrain(1, 50);
        waitDrain(2, 50);

        $display("[TB] DEPTH=4 fill with sink stalled");
        applyStimulus(3, 8'h11);
        applyStimulus(3, 8'h22);
        applyStimulus(3, 8'h33);
        applyStimulus(3, 8'h44);
        checkOutput("ready_after4", in_ready3, 1'b1);
        applyStimulus(3, 8'h55);
        checkOutput("ready_after5", in_ready3, 1'b0);
        checkOutput("ovf_after5",   ovf3,      1'b0);
        applyStimulus(3, 8'h66);
        checkOutput("ovf_after6",   ovf3,      1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ovf_sticky",   ovf3,      1'b1);
        checkOutput("still_full",   in_ready3, 1'b0);
        pushBits(3, 8'h11);
        pushBits(3, 8'h22);
        pushBits(3, 8'h33);
        pushBits(3, 8'h44);
        pushBits(3, 8'h55);
        out_ready3 = 1'b1;
        waitDrain(3, 200);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("ovf_after_drain",   ovf3,       1'b1);
        checkOutput("ready_after_drain", in_ready3,  1'b1);
        checkOutput("idle_after_drain",  out_valid3, 1'b0);

`ifdef PARAM_SER_FIFO_LEVEL_EN
        $display("[TB] level with sink stalled");
        out_ready0 = 1'b0;
        applyStimulus(0, 8'h01);
        applyStimulus(0, 8'h02);
        applyStimulus(0, 8'h03);
        checkOutput("level_after3", level0, 2);
        pushBits(0, 8'h01);
        pushBits(0, 8'h02);
        pushBits(0, 8'h03);
        out_ready0 = 1'b1;
        waitDrain(0, 100);
        checkOutput("level_drained", level0, 0);
`endif

        $display("[TB] reset in the middle of the second byte");
        repeat (2) @(posedge clk);
        #1;
        accepted0 = 0;
        pushBits(0, 8'h07);
        pushBits(0, 8'h03);
        pushBits(0, 8'h01);
        applyStimulus(0, 8'h07);
        applyStimulus(0, 8'h03);
        applyStimulus(0, 8'h01);
        for (int c = 0; c < 100 && accepted0 < 11; c++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("mid_byte_reached", (accepted0 >= 11), 1'b1);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_valid", out_valid0, 1'b0);
        checkOutput("midrst_out",   out0,       1'b0);
        checkOutput("midrst_ready", in_ready0,  1'b1);
        checkOutput("midrst_ovf",   ovf0,       1'b0);
`ifdef PARAM_SER_FIFO_LEVEL_EN
        checkOutput("midrst_level", level0, 0);
`endif
        q0.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        pushBits(0, 8'h55);
        applyStimulus(0, 8'h55);
        waitDrain(0, 50);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("final_idle0", out_valid0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
